divider_scheduler: RTL and testbench
====================================

Name: divider_scheduler

Overview:
- Shares one pipelined `divider` instance (fully pipelined, one op/cycle) among NUM_REQ independent requesters inside the AFU.
- Arbitrates requests round-robin and issues at most one operation per cycle.
- Tracks requester tags alongside the divider pipeline and returns each quotient to its owner through a per-requester response FIFO.
- Credit-limits each requester so its response FIFO can never overflow.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_LEN, 32, operand/result width.
- PIPELINE_STATE, 10, divider latency L in cycles, from operands on div_a/div_b to the matching div_result.
- MAX_OUTSTANDING, 4, per-requester limit on in-pipeline plus buffered results; also the response FIFO depth.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- flush  in  1  single-cycle pulse; discards all in-flight and buffered ops
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (at most one bit set)
- req_a  in  NUM_REQ*DATA_LEN  dividends, requester i at [i*DATA_LEN +: DATA_LEN]
- req_b  in  NUM_REQ*DATA_LEN  divisors, same packing as req_a
- rsp_valid  out  NUM_REQ  response available
- rsp_ready  in  NUM_REQ  response consumed
- rsp_data  out  NUM_REQ*DATA_LEN  quotients, same packing as req_a
- rsp_dbz  out  NUM_REQ  divisor-was-zero flag for the head response
- div_reset  out  1  reset to the divider
- div_a  out  DATA_LEN  registered dividend to the divider
- div_b  out  DATA_LEN  registered divisor to the divider
- div_result  in  DATA_LEN  divider quotient
- busy  out  1  any op in pipeline or any response FIFO non-empty

Behaviour:
- Reset: req_ready=0, rsp_valid=0, div_a=div_b=0, busy=0, all credit counters=0, tag pipeline cleared, RR pointer favours requester 0.
- div_reset = reset | flush | flush_d1, where flush_d1 is flush delayed by one cycle (combinational output).
- Eligibility: requester i is eligible when req_valid[i] & (outstanding[i] < MAX_OUTSTANDING) & !flush & !flush_d1.
- req_ready is combinational: exactly one grant to the first eligible requester at or after the RR pointer.
- On a handshake by requester i, the RR pointer moves to i+1 mod NUM_REQ. With no handshake, the pointer holds.
- Issue timing: handshake in cycle T → div_a/div_b carry the operands in cycle T+1.
- Idle cycles: div_a and div_b are driven to 0.
- Tag pipeline: L+1 stages of {valid, tag[$clog2(NUM_REQ)-1:0], dbz}. Stage 0 is loaded in lockstep with div_a, so the stage entry matches div_result in cycle T+1+L.
- Capture: in cycle T+1+L, {div_result, dbz} is written into FIFO[tag]. rsp_valid[tag] is high from cycle T+2+L, i.e. handshake-to-response = L+2 = 12 cycles at default.
- dbz = (req_b == 0) at issue. The op is still issued; div_result is passed through unchanged and is a don't-care.
- Response FIFOs: first-word-fall-through, depth MAX_OUTSTANDING. Pop on rsp_valid & rsp_ready. Capture and pop in the same cycle are both honoured.
- Per-requester FIFO order equals that requester's issue order.
- outstanding[i] accounting:
  - +1 on handshake.
  - −1 on pop.
  - Unchanged when both occur in the same cycle.
  - Width $clog2(MAX_OUTSTANDING+1).
- Overflow: a capture into a full FIFO is illegal; an assertion must fire. The credit scheme guarantees it cannot occur.
- Flush handling:
  - Flush in cycle F: all FIFOs, tag pipeline valids and counters clear at the end of F. div_a/div_b go to 0.
  - No grants in F or F+1.
  - Results arriving from the divider for flushed ops are ignored, because their tag-pipeline valids are cleared.
- Reset mid-operation behaves as flush, plus the RR pointer returns to 0.
- busy = OR(tag pipeline valids) | OR(rsp_valid).

Decomposition:
- Package divider_sched_pkg:
  - t_tag, sized $clog2(NUM_REQ) with a minimum of 1.
  - t_credit.
  - t_tag_stage struct {valid, tag, dbz}.
  - Default localparams.
- Sub-module divider_sched_rsp_fifo: parameterised FWFT FIFO, instantiated once per requester.
- The arbiter and tag pipeline stay inline.

Test Plan:
- Single op: requester 0, a=100, b=7, handshake in cycle T → rsp_valid[0] rises at T+12, rsp_data[0]=14, rsp_dbz[0]=0, busy drops after pop.
- Full contention: all 4 requesters hold req_valid with distinct operands (e.g. 1000/i+1) → grants 0,1,2,3,0,… one per cycle, no idle issue slots, every response correct and in order per requester.
- Credit stall: MAX_OUTSTANDING=2, requester 1 with rsp_ready=0 issues 3 ops → two handshakes, then req_ready[1] stays 0. A single pop re-enables it the next cycle, and other requesters keep issuing throughout.
- Divide by zero: a=55, b=0 → response with rsp_dbz=1. A neighbouring op 9/3 on another requester still returns 3 with dbz=0.
- Flush with 5 ops in flight and 2 buffered:
  - div_reset is high for 2 cycles and no response ever appears.
  - outstanding is 0 everywhere and no grant occurs in F or F+1.
  - A subsequent 81/9 returns 9 at the nominal latency.
- Reset asserted mid-stream for 3 cycles: all outputs return to their reset values, there are no stale responses afterward, and the RR pointer restarts at requester 0.

Source files
------------

// File: rtl/divider_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : divider_sched_pkg
// Brief   : Shared types, defaults and helpers for the divider scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package divider_sched_pkg;

    localparam int DEFAULT_NUM_REQ         = 4;
    localparam int DEFAULT_DATA_LEN        = 32;
    localparam int DEFAULT_PIPELINE_STATE  = 10;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_W    = clog2_min1(DEFAULT_NUM_REQ);
    localparam int CREDIT_W = $clog2(DEFAULT_MAX_OUTSTANDING + 1);

    // Types describe the default build; instances size their own copies.
    typedef logic [TAG_W-1:0]    t_tag;
    typedef logic [CREDIT_W-1:0] t_credit;

    typedef struct packed {
        logic valid;
        t_tag tag;
        logic dbz;
    } t_tag_stage;

endpackage : divider_sched_pkg
`default_nettype wire

// File: rtl/divider_sched_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : divider_sched_rsp_fifo
// Brief   : First-word-fall-through response FIFO, one per requester.
// Revision: 1.0 - initial release
// ============================================================================
module divider_sched_rsp_fifo
    import divider_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_LEN + 1,
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign valid  = (r_count != '0);
    assign w_full = (r_count == c_depth);
    assign w_push = push && !w_full;
    assign w_pop  = valid && ready;
    assign data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // The credit limit keeps captures away from a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && w_full));

endmodule : divider_sched_rsp_fifo
`default_nettype wire

// File: rtl/divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : divider_scheduler
// Brief   : Round-robin sharing of one pipelined divider among requesters.
// Revision: 1.0 - initial release
// ============================================================================
module divider_scheduler
    import divider_sched_pkg::*;
#(
    parameter int NUM_REQ         = DEFAULT_NUM_REQ,
    parameter int DATA_LEN        = DEFAULT_DATA_LEN,
    parameter int PIPELINE_STATE  = DEFAULT_PIPELINE_STATE,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [NUM_REQ*DATA_LEN-1:0]  rsp_data,
    output logic [NUM_REQ-1:0]           rsp_dbz,
    output logic                         div_reset,
    output logic [DATA_LEN-1:0]          div_a,
    output logic [DATA_LEN-1:0]          div_b,
    input  logic [DATA_LEN-1:0]          div_result,
    output logic                         busy
);

    localparam int REQ_TAG_W    = clog2_min1(NUM_REQ);
    localparam int REQ_CREDIT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LAT          = PIPELINE_STATE;

    typedef logic [REQ_TAG_W-1:0]    t_req_tag;
    typedef logic [REQ_CREDIT_W-1:0] t_req_credit;

    typedef struct packed {
        logic     valid;
        t_req_tag tag;
        logic     dbz;
    } t_stage;

    localparam t_req_tag    c_last_tag   = t_req_tag'(NUM_REQ - 1);
    localparam t_req_credit c_max_credit = t_req_credit'(MAX_OUTSTANDING);

    logic                r_flush_d1;
    t_req_tag            r_rr_ptr;
    t_req_credit         r_outstanding [NUM_REQ];
    t_stage              r_stage [LAT+1];
    logic [DATA_LEN-1:0] r_div_a;
    logic [DATA_LEN-1:0] r_div_b;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_pop;
    t_req_tag            w_grant_tag;
    t_req_tag            w_scan;
    logic                w_hs;
    logic [DATA_LEN-1:0] w_sel_a;
    logic [DATA_LEN-1:0] w_sel_b;
    t_stage              w_cap;
    logic                w_pipe_busy;

    assign div_reset = reset | flush | r_flush_d1;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign req_ready = w_grant;
    assign w_pop     = rsp_valid & rsp_ready;
    assign w_cap     = r_stage[LAT];

    // Grants are held off while the divider itself is being reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_valid[i] && (r_outstanding[i] < c_max_credit)
                            && !flush && !r_flush_d1 && !reset;
        end
    end

    always_comb begin
        w_grant     = '0;
        w_grant_tag = '0;
        w_hs        = 1'b0;
        w_scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = t_req_tag'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_hs && w_eligible[w_scan]) begin
                w_hs        = 1'b1;
                w_grant_tag = w_scan;
            end
        end
        if (w_hs) begin
            w_grant[w_grant_tag] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*DATA_LEN +: DATA_LEN];
                w_sel_b = req_b[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_d1 <= 1'b0;
            r_rr_ptr   <= '0;
            r_div_a    <= '0;
            r_div_b    <= '0;
        end else begin
            r_flush_d1 <= flush;
            r_div_a    <= w_hs ? w_sel_a : '0;
            r_div_b    <= w_hs ? w_sel_b : '0;
            if (w_hs) begin
                r_rr_ptr <= (w_grant_tag == c_last_tag) ? '0 : w_grant_tag + 1'b1;
            end
        end
    end

    // Stage 0 moves with div_a, so stage LAT lines up with div_result.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int s = 0; s <= LAT; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= '{valid: w_hs, tag: w_grant_tag, dbz: w_hs && (w_sel_b == '0)};
            for (int s = 1; s <= LAT; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_outstanding[i] <= r_outstanding[i] + 1'b1;
                    2'b01:   r_outstanding[i] <= r_outstanding[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        logic                w_push;
        logic [DATA_LEN:0]   w_head;

        assign w_push = w_cap.valid && (w_cap.tag == t_req_tag'(i));

        divider_sched_rsp_fifo #(
            .WIDTH (DATA_LEN + 1),
            .DEPTH (MAX_OUTSTANDING)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .clear     (flush),
            .push      (w_push),
            .push_data ({w_cap.dbz, div_result}),
            .valid     (rsp_valid[i]),
            .ready     (rsp_ready[i]),
            .data      (w_head)
        );

        assign rsp_data[i*DATA_LEN +: DATA_LEN] = w_head[DATA_LEN-1:0];
        assign rsp_dbz[i]                       = w_head[DATA_LEN];
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int s = 0; s <= LAT; s++) begin
            w_pipe_busy = w_pipe_busy | r_stage[s].valid;
        end
    end

    assign busy = w_pipe_busy | (|rsp_valid);

endmodule : divider_scheduler
`default_nettype wire

// File: tb/tb_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider_scheduler
// Brief   : Directed and random checks of divider_scheduler against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_divider_scheduler;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int L   = 10;
    localparam int MO  = 4;
    localparam int LAT = L + 2;

    logic           clk = 1'b0;
    logic           reset, flush;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_dbz;
    logic [N*W-1:0] req_a, req_b, rsp_data;
    logic           div_reset, busy;
    logic [W-1:0]   div_a, div_b, div_result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider_scheduler #(
        .NUM_REQ(N), .DATA_LEN(W), .PIPELINE_STATE(L), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dbz(rsp_dbz),
        .div_reset(div_reset), .div_a(div_a), .div_b(div_b), .div_result(div_result),
        .busy(busy)
    );

    // Divider stand-in: plain quotient, L cycles of latency, ignores its reset.
    logic [W-1:0] dpipe [L];
    always @(posedge clk) begin
        dpipe[0] <= (div_b == '0) ? '1 : div_a / div_b;
        for (int k = 1; k < L; k++) dpipe[k] <= dpipe[k-1];
    end
    assign div_result = dpipe[L-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: per-requester queue of ops granted but not yet consumed.
    typedef struct {
        logic [W-1:0] q;
        logic         dbz;
        int           rdy;
    } exp_t;

    exp_t         mq [N][$];
    int           m_rr = 0;
    int           mcyc = 0;
    logic         m_flush_prev = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [N-1:0] e_ready, e_valid;
    logic         e_busy;
    int           s;

    always @(negedge clk) begin
        logic [W-1:0] na, nb, a, b;
        exp_t         e;
        e_ready = '0;
        for (int k = 0; k < N; k++) begin
            s = (m_rr + k) % N;
            if (e_ready == '0 && req_valid[s] && mq[s].size() < MO && !flush && !m_flush_prev && !reset)
                e_ready[s] = 1'b1;
        end
        chk("req_ready", req_ready, e_ready);
        chk("div_reset", div_reset, reset | flush | m_flush_prev);
        chk("div_a", div_a, m_a);
        chk("div_b", div_b, m_b);
        e_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_valid[i] = mq[i].size() > 0 && mq[i][0].rdy <= mcyc;
            if (mq[i].size() > 0) e_busy = 1'b1;
            chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], e_valid[i]);
            if (e_valid[i]) begin
                chk($sformatf("rsp_dbz[%0d]", i), rsp_dbz[i], mq[i][0].dbz);
                if (!mq[i][0].dbz)
                    chk($sformatf("rsp_data[%0d]", i), rsp_data[i*W +: W], mq[i][0].q);
            end
        end
        chk("busy", busy, e_busy);

        na = '0;
        nb = '0;
        for (int i = 0; i < N; i++) begin
            if (e_valid[i] && rsp_ready[i]) void'(mq[i].pop_front());
            if (e_ready[i]) begin
                a = req_a[i*W +: W];
                b = req_b[i*W +: W];
                e.q   = (b == '0) ? '0 : a / b;
                e.dbz = (b == '0);
                e.rdy = mcyc + LAT;
                mq[i].push_back(e);
                m_rr = (i + 1) % N;
                na = a;
                nb = b;
            end
        end
        if (reset || flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
        end
        if (reset) m_rr = 0;
        m_a = na;
        m_b = nb;
        m_flush_prev = reset ? 1'b0 : flush;
        mcyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b, output int hs);
        req_valid[r] = 1'b1;
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        hs = -1;
        for (int t = 0; t < 100 && hs < 0; t++) begin
            @(negedge clk);
            if (req_ready[r]) hs = cyc;
            step();
        end
        req_valid[r] = 1'b0;
        chk("issue_granted", hs >= 0, 1);
    endtask

    task automatic wait_rsp(input int r, output int at, output logic [W-1:0] d, output logic z);
        at = -1;
        d  = '0;
        z  = 1'b0;
        for (int t = 0; t < 100 && at < 0; t++) begin
            @(negedge clk);
            if (rsp_valid[r] && rsp_ready[r]) begin
                at = cyc;
                d  = rsp_data[r*W +: W];
                z  = rsp_dbz[r];
            end
            step();
        end
        chk("rsp_arrived", at >= 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_idle", busy, 0);
        step();
    endtask

    initial begin
        int t0, t1, n1, nother, cnt, cnt0;
        logic [W-1:0] d;
        logic z;
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;

        // Reset state, with every requester asking.
        step();
        req_valid = '1;
        step();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_busy", busy, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        drain();

        // Single op 100/7.
        issue(0, 100, 7, t0);
        wait_rsp(0, t1, d, z);
        chk("single_latency", t1 - t0, 12);
        chk("single_q", d, 14);
        chk("single_dbz", z, 0);
        @(negedge clk);
        chk("single_busy_after_pop", busy, 0);
        step();

        // Full contention; pointer sits at 1 after the last grant to requester 0.
        req_valid = '1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = 1000 + $urandom_range(0, 9999);
                req_b[i*W +: W] = i + 1;
            end
            @(negedge clk);
            chk("contend_grant", req_ready, 4'b0001 << ((1 + k) % N));
            step();
        end
        req_valid = '0;
        drain();

        // Credit stall on requester 1 while the others keep issuing.
        rsp_ready = 4'b1101;
        req_valid = '1;
        n1 = 0;
        nother = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[1]) n1++;
            if (req_ready & 4'b1101) nother++;
            step();
        end
        chk("stall_hs_req1", n1, MO);
        chk("stall_others_issue", nother >= 20, 1);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("stall_still_blocked", req_ready, 0);
        chk("stall_buffered", rsp_valid[1], 1);
        step();
        rsp_ready = '1;
        @(negedge clk);
        chk("stall_pop_cycle_no_grant", req_ready, 0);
        step();
        rsp_ready = 4'b1101;
        @(negedge clk);
        chk("stall_reenabled", req_ready, 4'b0010);
        step();
        req_valid = '0;
        rsp_ready = '1;
        drain();

        // Divide by zero next to a normal op.
        issue(2, 55, 0, t0);
        issue(3, 9, 3, t0);
        wait_rsp(2, t1, d, z);
        chk("dbz_flag", z, 1);
        wait_rsp(3, t1, d, z);
        chk("dbz_neighbour_q", d, 3);
        chk("dbz_neighbour_flag", z, 0);
        drain();

        // Flush with 2 buffered on requester 0 and 5 in flight.
        rsp_ready = 4'b1110;
        issue(0, 40, 2, t0);
        issue(0, 50, 5, t0);
        repeat (14) step();
        req_valid = 4'b1110;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 5; k++) begin
            for (int i = 1; i < N; i++) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom_range(1, 300);
            end
            @(negedge clk);
            if (req_ready != '0) cnt++;
            step();
        end
        chk("flush_setup_issued", cnt, 5);
        req_valid = '1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_F_div_reset", div_reset, 1);
        chk("flush_F_no_grant", req_ready, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_F1_div_reset", div_reset, 1);
        chk("flush_F1_no_grant", req_ready, 0);
        chk("flush_F1_busy", busy, 0);
        step();
        req_valid = '0;
        rsp_ready = '1;
        cnt = 0;
        @(negedge clk);
        chk("flush_F2_div_reset", div_reset, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) cnt++;
        end
        chk("flush_no_stale_rsp", cnt, 0);
        step();
        issue(0, 81, 9, t0);
        wait_rsp(0, t1, d, z);
        chk("post_flush_latency", t1 - t0, 12);
        chk("post_flush_q", d, 9);
        drain();

        // Reset for 3 cycles in the middle of traffic.
        for (int k = 0; k < 20; k++) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = $urandom_range(1, 50);
            end
            step();
        end
        reset = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        step();
        step();
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_div_a", div_a, 0);
        chk("midrst_div_b", div_b, 0);
        chk("midrst_busy", busy, 0);
        step();
        reset = 1'b0;
        rsp_ready = '1;
        @(negedge clk);
        chk("midrst_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        cnt = 0;
        cnt0 = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid[N-1:1] != '0) cnt++;
            if (rsp_valid[0]) cnt0++;
        end
        chk("midrst_no_stale", cnt, 0);
        chk("midrst_one_rsp", cnt0, 1);
        step();

        // Random traffic with occasional flush and reset pulses.
        for (int k = 0; k < 800; k++) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = $urandom;
                req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 5000));
            end
            flush = !flush && !reset && ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_divider_scheduler
`default_nettype wire
